spi_poll_sequencer: RTL and testbench
=====================================

# spi_poll_sequencer

Periodic SPI poll sequencer for the SPI master subsystem. It arms the 3-second one-shot timer, consumes the timer's `done` pulse, and runs one chip-select-framed SPI transaction of `NUM_BYTES` bytes through the byte-level SPI master. It then reports the received word and re-arms the timer. It sits between the timer (it drives the timer's `start` and consumes its `done`) and the SPI byte engine.

## Interface
**Parameters**
- `NUM_BYTES`, default 2: bytes per transaction, range 1..8.
- `XFER_TIMEOUT`, default 1024: cycles allowed per byte for `spi_done` before abort, minimum 2.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  level; while high, polling runs continuously.
- `cmd_word`  in  8*NUM_BYTES  bytes to transmit; sampled in CS_SETUP.
- `timer_start`  out  1  one-cycle pulse to the timer's `start`.
- `timer_done`  in  1  one-cycle pulse from the timer.
- `spi_start`  out  1  one-cycle pulse requesting one byte transfer.
- `spi_tx_data`  out  8  byte to send; held stable from `spi_start` until `spi_done`.
- `spi_done`  in  1  one-cycle pulse; `spi_rx_data` is valid in the same cycle.
- `spi_rx_data`  in  8  received byte.
- `cs_n`  out  1  active-low slave select.
- `result`  out  8*NUM_BYTES  last complete received word.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `err_timeout`  out  1  one-cycle pulse on a byte timeout abort.
- `poll_count`  out  16  count of successful polls; wraps 0xFFFF -> 0.

## Operation
**Outputs**
- All outputs are registered.
- Reset values:
  - `cs_n` = 1.
  - All other outputs, including `result` and `poll_count`, = 0.

**States and transitions**
- IDLE: if `enable`, go to ARM.
- ARM: `timer_start` = 1 for one cycle, then go to WAIT_TMR.
- WAIT_TMR:
  - On `timer_done`, go to CS_SETUP.
  - If `enable` = 0 (and no `timer_done`), go to DRAIN.
- DRAIN: wait for `timer_done`, then go to IDLE. This prevents a new ARM pulse from being ignored by a still-running timer.
- CS_SETUP:
  - `cs_n` goes to 0.
  - Latch `cmd_word` into the tx shift register.
  - Clear the byte index and the rx shift register.
- XFER_START:
  - `spi_start` = 1.
  - `spi_tx_data` = tx byte at the current index, MSB byte first: byte i = `cmd_word[8*(NUM_BYTES-1-i) +: 8]`.
  - Clear the timeout counter.
- XFER_WAIT:
  - On `spi_done`: `rx` = {rx[8*NUM_BYTES-9:0], spi_rx_data}, index++.
  - If it was the last byte, go to CS_HOLD; otherwise go to XFER_START.
  - Otherwise the timeout counter increments. When it reaches XFER_TIMEOUT-1 without `spi_done`, go to ABORT.
  - If `spi_done` arrives in the same cycle as the terminal count, `spi_done` wins.
- CS_HOLD: `cs_n` stays 0 for one cycle, then go to REPORT.
- REPORT:
  - `cs_n` = 1, `result` <= rx, `result_valid` = 1, `poll_count`++.
  - Then go to ARM if `enable`, else IDLE.
- ABORT:
  - `cs_n` = 1, `err_timeout` = 1.
  - The partial rx is discarded; `result` and `poll_count` are unchanged.
  - Then go to ARM if `enable`, else IDLE.

**Other rules**
- `enable` is ignored from CS_SETUP through REPORT/ABORT; an in-flight transaction always completes or aborts.
- `spi_done` outside XFER_WAIT and `timer_done` outside WAIT_TMR/DRAIN are ignored.
- `rst` mid-transaction returns to IDLE immediately with `cs_n` = 1 and all pulses deasserted.

## Timing
- `timer_done` in cycle T (state WAIT_TMR):
  - T+1: `cs_n` = 0.
  - T+2: `spi_start` = 1.
- `spi_done` in cycle D:
  - Non-last byte: next `spi_start` at D+1.
  - Last byte: CS_HOLD at D+1, `result_valid` and `cs_n` = 1 at D+2, `timer_start` at D+3 if `enable`.
- Timeout: a byte with no `spi_done` gives `err_timeout` exactly XFER_TIMEOUT+1 cycles after its `spi_start` cycle.
- `enable` rising in IDLE: `timer_start` pulses 2 cycles later.

## Test plan
- Basic poll:
  - Stimulus: NUM_BYTES=2, `cmd_word`=0xA55A; SPI model returns 0x12 then 0x34; `timer_done` 10 cycles after `timer_start`.
  - Required: tx bytes 0xA5 then 0x5A, `result`=0x1234, one `result_valid`, `poll_count`=1, `timer_start` re-pulses at D+3.
- Cycle-exact latency:
  - Required: `cs_n` falls at T+1, `spi_start` at T+2, `cs_n` rises at D+2.
  - Required: `spi_tx_data` is stable between `spi_start` and `spi_done`.
- Timeout:
  - Stimulus: XFER_TIMEOUT=8; SPI model never asserts `spi_done` on byte 1.
  - Required: `err_timeout` pulse, `cs_n`=1, `result` and `poll_count` unchanged, re-arm follows.
  - Then, on a following cycle with `spi_done` arriving on the terminal-count cycle: the byte is accepted with no error.
- Disable during WAIT_TMR:
  - Stimulus: drop `enable`, then `timer_done` arrives.
  - Required: no `cs_n` activity, return to IDLE.
  - Stimulus: re-enable.
  - Required: `timer_start` 2 cycles later.
- Reset mid-XFER_WAIT:
  - Required: `cs_n`=1 and all outputs at reset values in the same cycle as `rst`.
  - Required: normal poll after `rst` releases.
- Wrap:
  - Stimulus: preload `poll_count`=0xFFFF via a forced sequence of successful polls (or force).
  - Required: next REPORT gives 0x0000.

Source files
------------

// File: rtl/spi_poll_sequencer.sv
// spi_poll_sequencer
//   Arms a one-shot timer, waits for its done pulse, then runs one chip-select
//   framed SPI transaction of NUM_BYTES bytes through a byte-level SPI master.
//   Bytes go out MSB byte first. The received word is reported and the timer
//   is re-armed while polling stays enabled.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   enable              level; polling runs while high (registered before use)
//   cmd_word            bytes to transmit, sampled in CS_SETUP
//   timer_start/done    one-cycle pulses to/from the one-shot timer
//   spi_start           one-cycle request for one byte transfer
//   spi_tx_data         byte to send, held from spi_start until spi_done
//   spi_done/rx_data    byte-complete pulse with received byte
//   cs_n                active-low slave select
//   result/result_valid last complete received word and its update pulse
//   err_timeout         one-cycle pulse when a byte transfer times out
//   poll_count          successful poll count, wraps at 16 bits
module spi_poll_sequencer #(
    parameter int NUM_BYTES    = 2,
    parameter int XFER_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [8*NUM_BYTES-1:0] cmd_word,
    output logic                   timer_start,
    input  logic                   timer_done,
    output logic                   spi_start,
    output logic [7:0]             spi_tx_data,
    input  logic                   spi_done,
    input  logic [7:0]             spi_rx_data,
    output logic                   cs_n,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   result_valid,
    output logic                   err_timeout,
    output logic [15:0]            poll_count
);
    localparam int WORD_W = 8 * NUM_BYTES;
    localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_W  = $clog2(XFER_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, ARM, WAIT_TMR, DRAIN, CS_SETUP,
        XFER_START, XFER_WAIT, CS_HOLD, REPORT, ABORT
    } state_t;

    state_t             state, state_nxt;
    logic               enable_q;
    logic [WORD_W-1:0]  tx_sr;
    logic [WORD_W-1:0]  rx_sr;
    logic [WORD_W-1:0]  rx_nxt;
    logic [IDX_W-1:0]   byte_idx;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               last_byte;
    logic               tmo_hit;

    assign last_byte = (byte_idx == IDX_W'(NUM_BYTES - 1));
    assign tmo_hit   = (tmo_cnt == CNT_W'(XFER_TIMEOUT - 1));

    always_comb begin
        rx_nxt      = rx_sr << 8;
        rx_nxt[7:0] = spi_rx_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (enable_q) state_nxt = ARM;
            ARM:        state_nxt = WAIT_TMR;
            WAIT_TMR: begin
                if (timer_done)     state_nxt = CS_SETUP;
                else if (!enable_q) state_nxt = DRAIN;
            end
            // The timer is still running; wait it out so a later ARM pulse
            // is not swallowed by a busy timer.
            DRAIN:      if (timer_done) state_nxt = IDLE;
            CS_SETUP:   state_nxt = XFER_START;
            XFER_START: state_nxt = XFER_WAIT;
            XFER_WAIT: begin
                // spi_done takes priority over the terminal count
                if (spi_done)     state_nxt = last_byte ? CS_HOLD : XFER_START;
                else if (tmo_hit) state_nxt = ABORT;
            end
            CS_HOLD:    state_nxt = REPORT;
            REPORT:     state_nxt = enable_q ? ARM : IDLE;
            ABORT:      state_nxt = enable_q ? ARM : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Control registers; outputs are decoded from the next state so each
    // pulse lines up with the cycle its state is occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            enable_q     <= 1'b0;
            timer_start  <= 1'b0;
            spi_start    <= 1'b0;
            cs_n         <= 1'b1;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            byte_idx     <= '0;
            tmo_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            enable_q     <= enable;
            timer_start  <= (state_nxt == ARM);
            spi_start    <= (state_nxt == XFER_START);
            cs_n         <= !(state_nxt inside {CS_SETUP, XFER_START, XFER_WAIT, CS_HOLD});
            result_valid <= (state_nxt == REPORT);
            err_timeout  <= (state_nxt == ABORT);

            if (state == CS_SETUP)
                byte_idx <= '0;
            else if (state == XFER_WAIT && spi_done)
                byte_idx <= byte_idx + IDX_W'(1);

            if (state == XFER_START)
                tmo_cnt <= '0;
            else if (state == XFER_WAIT && !spi_done && !tmo_hit)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Output data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_tx_data <= '0;
            result      <= '0;
            poll_count  <= '0;
        end else begin
            if (state == CS_SETUP)
                spi_tx_data <= cmd_word[WORD_W-1 -: 8];
            else if (state == XFER_WAIT && state_nxt == XFER_START)
                spi_tx_data <= tx_sr[WORD_W-1 -: 8];

            if (state_nxt == REPORT) begin
                result     <= rx_sr;
                poll_count <= poll_count + 16'd1;
            end
        end
    end

    // Internal shift registers; always initialised in CS_SETUP before use
    always_ff @(posedge clk) begin
        if (state == CS_SETUP) begin
            tx_sr <= cmd_word << 8;
            rx_sr <= '0;
        end else begin
            if (state == XFER_WAIT && state_nxt == XFER_START)
                tx_sr <= tx_sr << 8;
            if (state == XFER_WAIT && spi_done)
                rx_sr <= rx_nxt;
        end
    end

endmodule

// File: tb/tb_spi_poll_sequencer.sv
// Testbench for spi_poll_sequencer: table of directed poll transactions plus
// hand-written sequences for timeout, disable, reset and counter wrap.
module tb_spi_poll_sequencer;
    localparam int NB = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] cmd_word;
    logic        timer_start;
    logic        timer_done;
    logic        spi_start;
    logic [7:0]  spi_tx_data;
    logic        spi_done;
    logic [7:0]  spi_rx_data;
    logic        cs_n;
    logic [15:0] result;
    logic        result_valid;
    logic        err_timeout;
    logic [15:0] poll_count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
        logic [15:0] res;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [3];

    always #5 clk = ~clk;

    spi_poll_sequencer #(.NUM_BYTES(NB), .XFER_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cmd_word(cmd_word),
        .timer_start(timer_start), .timer_done(timer_done),
        .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_done(spi_done), .spi_rx_data(spi_rx_data),
        .cs_n(cs_n), .result(result), .result_valid(result_valid),
        .err_timeout(err_timeout), .poll_count(poll_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs_n"}, cs_n, 1);
        chk({tag, "_timer_start"}, timer_start, 0);
        chk({tag, "_spi_start"}, spi_start, 0);
        chk({tag, "_tx"}, spi_tx_data, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_pc"}, poll_count, 0);
    endtask

    // Entered at the negedge where timer_start was just seen (cycle A).
    // The timer answers 10 cycles later. Leaves at the first spi_start cycle.
    task automatic to_first_start(input logic [15:0] cmd, input logic [7:0] tx0);
        cmd_word = cmd;
        repeat (9) begin
            @(negedge clk);
            chk("cs_n_wait_tmr", cs_n, 1);
            chk("timer_start_low", timer_start, 0);
        end
        @(negedge clk);
        timer_done = 1'b1;
        chk("cs_n_at_T", cs_n, 1);
        @(negedge clk);
        timer_done = 1'b0;
        chk("cs_n_fall_T1", cs_n, 0);
        chk("spi_start_T1", spi_start, 0);
        @(negedge clk);
        chk("spi_start_T2", spi_start, 1);
        chk("tx_byte0", spi_tx_data, tx0);
    endtask

    task automatic run_poll(input logic [15:0] cmd, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] tx0, input logic [7:0] tx1,
                            input logic [15:0] res, input logic [15:0] cnt, input int dly);
        logic [7:0] rxb [2];
        logic [7:0] txb [2];
        rxb[0] = r0; rxb[1] = r1;
        txb[0] = tx0; txb[1] = tx1;
        to_first_start(cmd, tx0);
        for (int b = 0; b < 2; b++) begin
            if (b == 1) begin
                chk("spi_start_next", spi_start, 1);
                chk("tx_byte1", spi_tx_data, txb[1]);
            end
            for (int k = 1; k < dly; k++) begin
                @(negedge clk);
                chk("spi_start_low", spi_start, 0);
                chk("tx_stable", spi_tx_data, txb[b]);
            end
            @(negedge clk);
            spi_done    = 1'b1;
            spi_rx_data = rxb[b];
            chk("tx_stable_done", spi_tx_data, txb[b]);
            @(negedge clk);
            spi_done    = 1'b0;
            spi_rx_data = 8'h00;
            chk("err_low", err_timeout, 0);
        end
        chk("cs_n_hold", cs_n, 0);
        chk("rv_hold", result_valid, 0);
        @(negedge clk);
        chk("cs_n_rise_D2", cs_n, 1);
        chk("rv_D2", result_valid, 1);
        chk("result", result, res);
        chk("poll_count", poll_count, cnt);
        @(negedge clk);
        chk("rv_single", result_valid, 0);
        chk("rearm_D3", timer_start, 1);
    endtask

    task automatic run_timeout(input logic [15:0] cmd, input logic [7:0] tx0,
                               input logic [15:0] res, input logic [15:0] cnt);
        to_first_start(cmd, tx0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            chk("err_early", err_timeout, 0);
            chk("cs_n_xfer", cs_n, 0);
        end
        @(negedge clk);
        chk("err_pulse", err_timeout, 1);
        chk("cs_n_abort", cs_n, 1);
        chk("rv_abort", result_valid, 0);
        chk("result_kept", result, res);
        chk("pc_kept", poll_count, cnt);
        @(negedge clk);
        chk("err_single", err_timeout, 0);
        chk("rearm_abort", timer_start, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{cmd: 16'hA55A, r0: 8'h12, r1: 8'h34, tx0: 8'hA5, tx1: 8'h5A, res: 16'h1234, cnt: 16'd1};
        tbl[1] = '{cmd: 16'hFF00, r0: 8'h00, r1: 8'hFF, tx0: 8'hFF, tx1: 8'h00, res: 16'h00FF, cnt: 16'd2};
        tbl[2] = '{cmd: 16'h0F3C, r0: 8'hC3, r1: 8'h7E, tx0: 8'h0F, tx1: 8'h3C, res: 16'hC37E, cnt: 16'd3};

        rst = 1'b1; enable = 1'b0; timer_done = 1'b0; spi_done = 1'b0;
        spi_rx_data = 8'h00; cmd_word = 16'h0000;

        @(negedge clk);
        chk_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_arm", timer_start, 0);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("arm_E1", timer_start, 0);
        @(negedge clk);
        chk("arm_E2", timer_start, 1);

        for (int i = 0; i < 3; i++)
            run_poll(tbl[i].cmd, tbl[i].r0, tbl[i].r1, tbl[i].tx0, tbl[i].tx1,
                     tbl[i].res, tbl[i].cnt, 3);

        // Byte timeout, then spi_done exactly on the terminal-count cycle
        run_timeout(16'h1122, 8'h11, 16'hC37E, 16'd3);
        run_poll(16'h6699, 8'hAB, 8'hCD, 8'h66, 8'h99, 16'hABCD, 16'd4, TO);

        // Disable while waiting on the timer
        repeat (3) @(negedge clk);
        enable = 1'b0;
        for (int k = 4; k < 10; k++) begin
            @(negedge clk);
            chk("dis_cs_n", cs_n, 1);
            chk("dis_no_arm", timer_start, 0);
        end
        @(negedge clk);
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
        repeat (4) begin
            chk("dis_cs_n_after", cs_n, 1);
            chk("dis_spi_start", spi_start, 0);
            chk("dis_idle", timer_start, 0);
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("reen_E1", timer_start, 0);
        @(negedge clk);
        chk("reen_E2", timer_start, 1);

        // Reset during XFER_WAIT
        to_first_start(16'h4321, 8'h43);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_E1", timer_start, 0);
        @(negedge clk);
        chk("post_rst_E2", timer_start, 1);
        run_poll(16'h1357, 8'h24, 8'h68, 8'h13, 8'h57, 16'h2468, 16'd1, 2);

        // Counter wrap
        force dut.poll_count = 16'hFFFF;
        #1;
        release dut.poll_count;
        chk("pc_preload", poll_count, 16'hFFFF);
        run_poll(16'h8001, 8'h9A, 8'hBC, 8'h80, 8'h01, 16'h9ABC, 16'd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
